// File: rtl/vm_pkg.sv
// Shared types for the vending-machine output side: one-hot dispense FSM
// state encoding, coin-count width and a small constant helper.
package vm_pkg;

   localparam int COIN_W = 3;

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_PROD  = 5'b00010,
      ST_COIN  = 5'b00100,
      ST_GAP   = 5'b01000,
      ST_FAULT = 5'b10000
   } disp_state_t;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/vm_disp_fifo.sv
// Transaction queue for vm_dispense: first-word-fall-through FIFO holding the
// coin count of each vend. A push into a full queue is taken only if a pop
// frees a slot in the same cycle.
module vm_disp_fifo
   import vm_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = COIN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   // Flag decode; the extra pointer bit tells full from empty.
   always_comb begin
      empty     = (wr_ptr_r == rd_ptr_r);
      full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_ok_s  = pop && !empty;
      push_ok_s = push && (!full || pop_ok_s);
      dout      = mem_r[rd_ptr_r[AW-1:0]];
   end

   // Storage and pointer update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/vm_dispense.sv
// Dispense controller: queues vends, pulses the product actuator, then pays
// change one coin at a time via coin_req/coin_ack. Optional hopper timeout
// is enabled by defining VM_DISP_TIMEOUT_EN.
module vm_dispense
   import vm_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int PROD_CYC = 3,
   parameter int GAP_CYC  = 2,
   parameter int TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vend,
   input  logic [COIN_W-1:0] change,
   input  logic              coin_ack,
   output logic              prod_out,
   output logic              coin_req,
   output logic [COIN_W-1:0] pend,
   output logic              busy,
   output logic              ovf,
   output logic              fault
);

   localparam int CW = $clog2(imax(imax(PROD_CYC, GAP_CYC), TIMEOUT) + 1);
   localparam logic [CW-1:0] PROD_LAST = CW'(PROD_CYC - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
`ifdef VM_DISP_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
`endif

   disp_state_t       state_r;
   disp_state_t       state_nx_s;
   logic [CW-1:0]     cnt_r;
   logic [COIN_W-1:0] pend_r;
   logic              ovf_r;
   logic [COIN_W-1:0] fifo_dout_s;
   logic              full_s;
   logic              empty_s;
   logic              pop_s;

   assign pop_s = (state_r == ST_IDLE) && !empty_s;

   vm_disp_fifo #(.DEPTH(DEPTH), .WIDTH(COIN_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (vend),
      .pop   (pop_s),
      .din   (change),
      .dout  (fifo_dout_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; an ack in the same cycle as the timeout wins.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s) state_nx_s = ST_PROD;
            else          state_nx_s = ST_IDLE;
         end
         ST_PROD: begin
            if (cnt_r == PROD_LAST) begin
               if (pend_r == 3'd0) state_nx_s = ST_IDLE;
               else                state_nx_s = ST_COIN;
            end else begin
               state_nx_s = ST_PROD;
            end
         end
         ST_COIN: begin
            if (coin_ack) begin
               state_nx_s = ST_GAP;
`ifdef VM_DISP_TIMEOUT_EN
            end else if (cnt_r == TO_LAST) begin
               state_nx_s = ST_FAULT;
`endif
            end else begin
               state_nx_s = ST_COIN;
            end
         end
         ST_GAP: begin
            if (cnt_r == GAP_LAST) begin
               if (pend_r == 3'd0) state_nx_s = ST_IDLE;
               else                state_nx_s = ST_COIN;
            end else begin
               state_nx_s = ST_GAP;
            end
         end
         ST_FAULT: state_nx_s = ST_FAULT;
         default:  state_nx_s = ST_IDLE;
      endcase
   end

   // Outputs decode only from registers.
   always_comb begin
      prod_out = (state_r == ST_PROD);
      coin_req = (state_r == ST_COIN);
      pend     = pend_r;
      busy     = (state_r != ST_IDLE) || !empty_s;
      ovf      = ovf_r;
`ifdef VM_DISP_TIMEOUT_EN
      fault    = (state_r == ST_FAULT);
`else
      fault    = 1'b0;
`endif
   end

   // Dwell counter: restarts on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if ((state_nx_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_FAULT)) begin
         cnt_r <= {CW{1'b0}};
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   // Pending coins and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= 3'd0;
         ovf_r  <= 1'b0;
      end else begin
         if (pop_s) begin
            pend_r <= fifo_dout_s;
         end else if ((state_r == ST_COIN) && coin_ack) begin
            pend_r <= pend_r - 3'd1;
         end else begin
            pend_r <= pend_r;
         end
         if (vend && full_s && !pop_s) begin
            ovf_r <= 1'b1;
         end else begin
            ovf_r <= ovf_r;
         end
      end
   end

endmodule

// File: tb/tb_vm_dispense.sv
// Self-checking bench for vm_dispense: per-cycle vector table plus directed
// sequences for overflow, hopper wait/timeout (VM_DISP_TIMEOUT_EN) and reset.
module tb_vm_dispense;

   logic       clk = 1'b0;
   logic       rst;
   logic       vend;
   logic [2:0] change;
   logic       coin_ack;
   logic       prod_out;
   logic       coin_req;
   logic [2:0] pend;
   logic       busy;
   logic       ovf;
   logic       fault;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       vend;
      logic [2:0] change;
      logic       ack;
      logic       prod;
      logic       req;
      logic [2:0] pend;
      logic       busy;
   } vec_t;

   vec_t tbl [20];

   vm_dispense #(.DEPTH(4), .PROD_CYC(3), .GAP_CYC(2), .TIMEOUT(255)) dut (
      .clk      (clk),
      .rst      (rst),
      .vend     (vend),
      .change   (change),
      .coin_ack (coin_ack),
      .prod_out (prod_out),
      .coin_req (coin_req),
      .pend     (pend),
      .busy     (busy),
      .ovf      (ovf),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic serve_coins(input int n);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         while (!coin_req && t < 100) begin
            tick;
            t++;
         end
         chk("coin_req_wait", {31'd0, coin_req}, 32'd1);
         coin_ack = 1'b1;
         tick;
         coin_ack = 1'b0;
      end
   endtask

   task automatic run_txn(input int exp_ch);
      int t = 0;
      while (!prod_out && t < 50) begin
         tick;
         t++;
      end
      chk("txn_prod_wait", {31'd0, prod_out}, 32'd1);
      chk("txn_order_pend", {29'd0, pend}, exp_ch);
      serve_coins(exp_ch);
   endtask

   task automatic wait_idle;
      int t = 0;
      while (busy && t < 100) begin
         tick;
         t++;
      end
      chk("idle_wait_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Scenario A: change=0 then an ack while idle.
      tbl[0]  = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      tbl[2]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      tbl[3]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
      tbl[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      tbl[5]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
      // Scenario B: change=3, ack during PROD ignored, ack one cycle into each req.
      tbl[6]  = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[7]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1};
      tbl[8]  = '{1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1};
      tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1};
      tbl[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1};
      tbl[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[12] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
      tbl[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
      tbl[14] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
      tbl[16] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
      tbl[17] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[18] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
      tbl[19] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};

      rst = 1'b1;
      vend = 1'b0;
      change = 3'd0;
      coin_ack = 1'b0;
      repeat (3) tick;
      chk("rst_prod", {31'd0, prod_out}, 32'd0);
      chk("rst_req", {31'd0, coin_req}, 32'd0);
      chk("rst_pend", {29'd0, pend}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < 20; i++) begin
         vend = tbl[i].vend;
         change = tbl[i].change;
         coin_ack = tbl[i].ack;
         tick;
         chk($sformatf("vec%0d_prod", i), {31'd0, prod_out}, {31'd0, tbl[i].prod});
         chk($sformatf("vec%0d_req", i), {31'd0, coin_req}, {31'd0, tbl[i].req});
         chk($sformatf("vec%0d_pend", i), {29'd0, pend}, {29'd0, tbl[i].pend});
         chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
         chk($sformatf("vec%0d_ovf", i), {31'd0, ovf}, 32'd0);
         chk($sformatf("vec%0d_fault", i), {31'd0, fault}, 32'd0);
      end
      vend = 1'b0;
      coin_ack = 1'b0;

      // Overflow: T0 (1 coin) enters PROD, then 5 back-to-back vends.
      vend = 1'b1; change = 3'd1; tick;
      vend = 1'b0; tick;
      chk("ovf_t0_prod", {31'd0, prod_out}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         vend = 1'b1;
         change = 3'(i + 2);
         tick;
         if (i == 3) chk("ovf_before_drop", {31'd0, ovf}, 32'd0);
      end
      vend = 1'b0;
      chk("ovf_after_drop", {31'd0, ovf}, 32'd1);
      serve_coins(1);
      run_txn(2);
      run_txn(3);
      run_txn(4);
      run_txn(5);
      wait_idle;
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);

      // Hopper never acks.
      begin
         int n = 0;
         vend = 1'b1; change = 3'd2; tick;
         vend = 1'b0;
         while (!coin_req && n < 20) begin
            tick;
            n++;
         end
         chk("noack_req_seen", {31'd0, coin_req}, 32'd1);
         n = 0;
         while (coin_req && n < 300) begin
            n++;
            tick;
         end
`ifdef VM_DISP_TIMEOUT_EN
         chk("to_coin_cycles", n, 32'd255);
         chk("to_fault", {31'd0, fault}, 32'd1);
         chk("to_req_low", {31'd0, coin_req}, 32'd0);
         coin_ack = 1'b1;
         repeat (20) tick;
         coin_ack = 1'b0;
         chk("to_fault_held", {31'd0, fault}, 32'd1);
         chk("to_req_held_low", {31'd0, coin_req}, 32'd0);
         chk("to_prod_low", {31'd0, prod_out}, 32'd0);
         rst = 1'b1; #2;
         chk("to_fault_cleared", {31'd0, fault}, 32'd0);
         tick;
         rst = 1'b0;
         tick;
`else
         chk("wait_coin_cycles", n, 32'd300);
         chk("wait_req_held", {31'd0, coin_req}, 32'd1);
         chk("wait_fault_zero", {31'd0, fault}, 32'd0);
         serve_coins(2);
         wait_idle;
`endif
      end

      // Reset during COIN with 2 coins pending and 2 entries queued.
      begin
         int t = 0;
         vend = 1'b1; change = 3'd2; tick;
         change = 3'd1; tick;
         change = 3'd3; tick;
         vend = 1'b0;
         while (!coin_req && t < 20) begin
            tick;
            t++;
         end
         chk("mid_req_up", {31'd0, coin_req}, 32'd1);
         chk("mid_pend2", {29'd0, pend}, 32'd2);
         rst = 1'b1;
         #1;
         chk("mid_rst_req", {31'd0, coin_req}, 32'd0);
         chk("mid_rst_prod", {31'd0, prod_out}, 32'd0);
         chk("mid_rst_pend", {29'd0, pend}, 32'd0);
         chk("mid_rst_busy", {31'd0, busy}, 32'd0);
         chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
         tick;
         rst = 1'b0;
         coin_ack = 1'b1;
         for (int i = 0; i < 12; i++) begin
            tick;
            if (i == 11) begin
               chk("post_rst_req", {31'd0, coin_req}, 32'd0);
               chk("post_rst_prod", {31'd0, prod_out}, 32'd0);
               chk("post_rst_busy", {31'd0, busy}, 32'd0);
            end
            if (coin_req || prod_out) begin
               chk($sformatf("post_rst_quiet%0d", i), {31'd0, coin_req | prod_out}, 32'd0);
            end
         end
         coin_ack = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
